// File: rtl/pe_psum_drain.sv
// Row-sum drain for the 11x11 PE psum matrix: snapshot, reduce KxK rows, stream.
// Optional macro PE_DRAIN_RELU_EN clamps negative row sums to zero at the output.
module pe_psum_drain #(
    parameter int DataWidth = 8
) (
    input  logic                                   CLK,
    input  logic                                   RST,
    input  logic [1:0]                             sel,
    input  logic                                   cap,
    input  logic [10:0][10:0][2*DataWidth-1:0]     Bus_P,
    output logic                                   busy,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [2*DataWidth+3:0]                 out_data,
    output logic [3:0]                             out_row,
    output logic                                   out_last
);

    localparam int PW = 2 * DataWidth;
    localparam int SW = PW + 4;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        OUT
    } state_t;

    state_t                          state_q, state_d;
    logic [10:0][10:0][PW-1:0]       snap_q, snap_d;
    logic [3:0]                      k_q, k_d;
    logic [3:0]                      row_q, row_d;
    logic [3:0]                      col_q, col_d;
    logic [SW-1:0]                   acc_q, acc_d;
    logic                            busy_q, busy_d;
    logic                            valid_q, valid_d;
    logic                            last_q, last_d;
    logic [3:0]                      k_sel;
    logic [PW-1:0]                   word;
    logic [SW-1:0]                   term;

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        k_d     = k_q;
        row_d   = row_q;
        col_d   = col_q;
        acc_d   = acc_q;

        unique case (sel)
            2'd0:    k_sel = 4'd3;
            2'd1:    k_sel = 4'd5;
            2'd2:    k_sel = 4'd7;
            default: k_sel = 4'd11;
        endcase

        word = snap_q[row_q][col_q];
        term = {{4{word[PW-1]}}, word};

        unique case (state_q)
            IDLE: begin
                if (cap) begin
                    snap_d  = Bus_P;
                    k_d     = k_sel;
                    row_d   = 4'd0;
                    col_d   = 4'd0;
                    acc_d   = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                acc_d = acc_q + term;
                col_d = col_q + 4'd1;
                if (col_q == k_q - 4'd1) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    if (row_q == k_q - 4'd1) begin
                        state_d = IDLE;
                    end else begin
                        row_d   = row_q + 4'd1;
                        col_d   = 4'd0;
                        acc_d   = '0;
                        state_d = ACC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next-state view.
        busy_d  = (state_d != IDLE);
        valid_d = (state_d == OUT);
        last_d  = (state_d == OUT) && (row_d == k_d - 4'd1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            snap_q  <= '0;
            k_q     <= 4'd3;
            row_q   <= 4'd0;
            col_q   <= 4'd0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            k_q     <= k_d;
            row_q   <= row_d;
            col_q   <= col_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_row   = row_q;
    assign out_last  = last_q;

`ifdef PE_DRAIN_RELU_EN
    assign out_data = acc_q[SW-1] ? '0 : acc_q;
`else
    assign out_data = acc_q;
`endif

endmodule

// File: tb/tb_pe_psum_drain.sv
// Scoreboard bench for pe_psum_drain: model pushes row sums, monitor pops on handshake.
module tb_pe_psum_drain;

    logic                         CLK = 1'b0;
    logic                         RST;
    logic [1:0]                   sel;
    logic                         cap;
    logic [10:0][10:0][15:0]      bus;
    logic                         busy;
    logic                         out_valid;
    logic                         out_ready;
    logic [19:0]                  out_data;
    logic [3:0]                   out_row;
    logic                         out_last;

    int total = 0;
    int bad   = 0;
    int rdy_mode = 0;
    int stall_cnt = 0;
    logic [24:0] expq[$];

    pe_psum_drain #(.DataWidth(8)) dut (
        .CLK(CLK), .RST(RST), .sel(sel), .cap(cap), .Bus_P(bus),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_last(out_last)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int k_of(input int s);
        case (s)
            0: return 3;
            1: return 5;
            2: return 7;
            default: return 11;
        endcase
    endfunction

    task automatic push_rows(input int k, input int nrows);
        for (int r = 0; r < nrows; r++) begin
            int s;
            logic [19:0] d;
            s = 0;
            for (int c = 0; c < k; c++) s += int'($signed(bus[r][c]));
`ifdef PE_DRAIN_RELU_EN
            if (s < 0) s = 0;
`endif
            d = s[19:0];
            expq.push_back({d, 4'(r), (r == k - 1)});
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // Ready driver: reacts to the registered outputs just after each edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            if (rdy_mode == 1) begin
                out_ready = ($urandom % 4) != 0;
            end else if (rdy_mode == 2 && out_valid && out_row == 4'd1
                         && stall_cnt < 4) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted beat, checks hold while stalled.
    initial begin
        logic        stalled;
        logic [19:0] pd;
        logic [3:0]  pr;
        logic        pl;
        logic [24:0] e;
        stalled = 1'b0;
        pd = '0; pr = '0; pl = 1'b0;
        forever begin
            @(negedge CLK);
            if (stalled) begin
                total++;
                if (!(out_valid && out_data == pd && out_row == pr && out_last == pl)) begin
                    bad++;
                    $display("FAIL hold: v=%0b d=%h r=%0d l=%0b want d=%h r=%0d l=%0b",
                             out_valid, out_data, out_row, out_last, pd, pr, pl);
                end
            end
            stalled = out_valid && !out_ready && !RST;
            pd = out_data; pr = out_row; pl = out_last;
            if (out_valid && out_ready && !RST) begin
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL beat: unexpected d=%h r=%0d l=%0b",
                             out_data, out_row, out_last);
                end else begin
                    e = expq.pop_front();
                    if ({out_data, out_row, out_last} != e) begin
                        bad++;
                        $display("FAIL beat: got d=%h r=%0d l=%0b want d=%h r=%0d l=%0b",
                                 out_data, out_row, out_last, e[24:5], e[4:1], e[0]);
                    end
                end
            end
        end
    end

    task automatic run_frame(input int s, input int mode, input bit disturb,
                             input bit timing);
        int k, n, first;
        k = k_of(s);
        sel = 2'(s);
        rdy_mode = mode;
        stall_cnt = 0;
        push_rows(k, k);
        @(negedge CLK);
        cap = 1'b1;
        @(posedge CLK);
        #1;
        cap = 1'b0;
        check("busy_rise", int'(busy), 1);
        n = 0;
        first = -1;
        while (busy && n < 3000) begin
            @(posedge CLK);
            n++;
            #1;
            if (first < 0 && out_valid) first = n;
            if (disturb && n >= 2 && n <= 5) begin
                cap = 1'b1;
                sel = 2'($urandom);
                for (int r = 0; r < 11; r++)
                    for (int c = 0; c < 11; c++) bus[r][c] = 16'($urandom);
            end else if (disturb) begin
                cap = 1'b0;
            end
        end
        cap = 1'b0;
        if (n >= 3000) check("frame_timeout", n, 0);
        if (timing) begin
            check("first_valid", first, k);
            check("frame_len", n, k * (k + 1));
        end
        if (mode == 2) check("stall_cycles", stall_cnt, 4);
        check("queue_empty", expq.size(), 0);
        expq.delete();
        rdy_mode = 0;
    endtask

    task automatic rand_bus();
        for (int r = 0; r < 11; r++)
            for (int c = 0; c < 11; c++) bus[r][c] = 16'($urandom);
    endtask

    initial begin
        int n;
        RST = 1'b1;
        cap = 1'b0;
        sel = 2'd0;
        bus = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_row", int'(out_row), 0);
        check("rst_last", int'(out_last), 0);
        RST = 1'b0;

        for (int r = 0; r < 11; r++)
            for (int c = 0; c < 11; c++) bus[r][c] = 16'd1;
        run_frame(0, 0, 1'b0, 1'b1);

        for (int r = 0; r < 11; r++)
            for (int c = 0; c < 11; c++) bus[r][c] = 16'(11 * r + c);
        run_frame(3, 0, 1'b0, 1'b1);

        for (int r = 0; r < 11; r++)
            for (int c = 0; c < 11; c++) bus[r][c] = 16'hFFFF;
        run_frame(1, 0, 1'b0, 1'b1);

        rand_bus();
        run_frame(0, 2, 1'b0, 1'b0);

        rand_bus();
        run_frame(2, 0, 1'b1, 1'b1);

        // Abort during the ACC phase of row 1; only row 0 is ever delivered.
        rand_bus();
        sel = 2'd0;
        push_rows(3, 1);
        @(negedge CLK);
        cap = 1'b1;
        @(posedge CLK);
        #1;
        cap = 1'b0;
        n = 0;
        while (n < 5) begin
            @(posedge CLK);
            n++;
        end
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(out_valid), 0);
        check("abort_last", int'(out_last), 0);
        check("abort_queue", expq.size(), 0);
        expq.delete();

        rand_bus();
        run_frame(0, 0, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            rand_bus();
            run_frame(int'($urandom_range(0, 3)), (i % 2 == 0) ? 1 : 0, 1'b0, (i % 2) != 0);
        end

        repeat (3) @(posedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_psum_drain.md
# pe_psum_drain

Drain engine on the output side of the 11x11 PE matrix. It snapshots the full partial-sum bus `Bus_P` on a capture strobe and reduces the active KxK window row by row. Each row sum is emitted as one beat on a valid/ready stream toward the output buffer. The kernel window K comes from the same `sel` code that configures the PE arrays, so the matrix and the drain always agree on geometry.

## Interface
- `DataWidth`, default 8: PE operand width. Psum width is 2*DataWidth; row-sum width is 2*DataWidth+4.
- `CLK` input, 1 bit: the single clock; all logic is on the rising edge.
- `RST` input, 1 bit: synchronous, active-high reset.
- `sel` input, [1:0]: window code. 0 selects K=3, 1 selects K=5, 2 selects K=7, 3 selects K=11.
- `cap` input, 1 bit: capture strobe. Sampled only in IDLE.
- `Bus_P` input, [2*DataWidth-1:0] [10:0][10:0]: PE matrix psums, signed two's complement, indexed [row][col].
- `busy` output, 1 bit: high whenever state is not IDLE.
- `out_valid` output, 1 bit: a row sum is presented.
- `out_ready` input, 1 bit: consumer accepts the beat.
- `out_data` output, [2*DataWidth+3:0]: signed row sum.
- `out_row` output, [3:0]: row index of the current beat.
- `out_last` output, 1 bit: marks the final row (row == K-1).

## Operation
- FSM states are IDLE, ACC and OUT.
- IDLE with `cap`=1:
  - Latch all 121 `Bus_P` words into a snapshot register.
  - Latch K decoded from `sel`.
  - Clear row, col and acc to 0, then go to ACC.
- ACC, once per cycle:
  - acc ← acc + sign-extended snapshot[row][col], then col++.
  - On the cycle that adds col == K-1, go to OUT.
- OUT:
  - `out_valid`=1. `out_data` is the final acc (after the optional ReLU). `out_row` is row. `out_last` is (row == K-1).
  - On `out_valid && out_ready`: if row == K-1, go to IDLE; otherwise row++, col←0, acc←0, and go back to ACC.
- Columns and rows ≥ K are never read.
- `cap` is ignored outside IDLE. `sel` and `Bus_P` changes after capture have no effect on the frame in progress.
- Arithmetic: 11 terms of 16 bits fit in 20 bits, so the sum never overflows and never wraps.

## Timing
- Reset: state=IDLE, `busy`=0, `out_valid`=0, `out_data`=0, `out_row`=0, `out_last`=0, and the snapshot and acc are cleared.
- Let E0 be the edge that samples `cap`=1 in IDLE.
  - `busy` rises after E0.
  - The first `out_valid` rises after edge E0+K.
- Each row costs K ACC cycles plus at least 1 OUT cycle.
- With `out_ready` tied high, a frame takes K(K+1) cycles and `busy` falls after edge E0+K(K+1). For K=3 that is 12 cycles.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_data`, `out_row` and `out_last` hold stable.
- After the last beat is accepted, the block returns to IDLE. A `cap` on the very next cycle is accepted; no dead cycle is required.
- `RST` mid-frame aborts the frame immediately, with no partial beat and no `out_last`, and returns to reset values on the next edge.
- `out_ready` while `out_valid`=0 has no effect.

## Configuration
- Macro `PE_DRAIN_RELU_EN`.
- When defined, `out_data` = (acc < 0) ? 0 : acc. The ReLU is applied combinationally at the output of the OUT state, and latency is unchanged.
- When undefined, `out_data` = acc, signed, with no clamping.

## Test plan
- All `Bus_P`=1, `sel`=0, `cap` pulse, `out_ready`=1:
  - 3 beats, each `out_data`=3, `out_row`=0,1,2, with `out_last` only on row 2.
  - First valid K=3 cycles after E0; `busy` falls after edge E0+12.
- `sel`=3, `Bus_P[r][c]`=11r+c:
  - 11 beats with `out_data`=121r+55 (55, 176, …, 1265).
  - `out_last` on row 10; total 132 cycles.
- `sel`=1, all `Bus_P`=16'hFFFF:
  - Without the macro: 5 beats of 20'hFFFFB (-5).
  - With `PE_DRAIN_RELU_EN`: 5 beats of 0.
- Backpressure, `sel`=0, `out_ready` low for 4 cycles on row 1:
  - `out_data`, `out_row`=1 and `out_last`=0 hold stable.
  - No beat is lost or duplicated.
- `cap` pulsed while `busy`, with `Bus_P` changed after E0:
  - No restart, and the sums reflect the original snapshot.
- `RST` asserted during ACC of row 1:
  - Next cycle `busy`=0 and `out_valid`=0.
  - A later `cap` runs a full, correct frame.
